// File: rtl/add16.sv
// rtl/add16.sv - 16-bit carry-lookahead adder with registered sum and flags
//
// Purpose:
//   Computes s = X + Y + cin (mod 2^WIDTH) with one clock of latency. The
//   carry chain is built from GROUP-bit carry-lookahead groups. Carries ripple
//   from one group to the next. Status flags are registered together with the
//   sum.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous reset, active low
//   X      in   WIDTH  operand A
//   Y      in   WIDTH  operand B
//   cin    in   1      carry in
//   s      out  WIDTH  registered sum
//   cout   out  1      registered unsigned carry out of the MSB
//   ovf    out  1      registered signed overflow
//   zero   out  1      registered, high when s == 0
//
// WIDTH must be a multiple of GROUP.

module add16 #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NGRP = WIDTH / GROUP;

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH:0]   c;
   logic             grp_cin;
   logic             term;
   logic             prod;

   logic [WIDTH-1:0] s_d,    s_q;
   logic             cout_d, cout_q;
   logic             ovf_d,  ovf_q;
   logic             zero_d, zero_q;

   assign g = X & Y;
   assign p = X ^ Y;

   // Inside a group, every carry is written in flat two-level form from the
   // group carry-in: c[b+j+1] = OR_m (g[b+m] & p[b+m+1..b+j]) | (p[b..b+j] & cin_grp).
   // Only the group carry-in ripples from one group to the next.
   always_comb begin
      c       = '0;
      grp_cin = cin;
      term    = 1'b0;
      prod    = 1'b0;
      c[0]    = cin;
      for (int grp = 0; grp < NGRP; grp++) begin
         for (int j = 0; j < GROUP; j++) begin
            // Propagate path straight from the group carry-in.
            prod = grp_cin;
            for (int k = 0; k <= j; k++) begin
               prod = prod & p[grp*GROUP + k];
            end
            term = prod;
            // Generate at bit m, propagated through bits m+1..j.
            for (int m = 0; m <= j; m++) begin
               prod = g[grp*GROUP + m];
               for (int k = m + 1; k <= j; k++) begin
                  prod = prod & p[grp*GROUP + k];
               end
               term = term | prod;
            end
            c[grp*GROUP + j + 1] = term;
         end
         grp_cin = c[(grp + 1) * GROUP];
      end
   end

   always_comb begin
      s_d    = p ^ c[WIDTH-1:0];
      cout_d = c[WIDTH];
      // Signed overflow occurs when the carry into the sign bit differs from
      // the carry out of the sign bit.
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
      zero_d = ~|s_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_add16.sv
// tb/tb_add16.sv - randomized self-checking bench for add16 against an arithmetic model

module tb_add16;

   logic        clk;
   logic        rst_n;
   logic [15:0] X;
   logic [15:0] Y;
   logic        cin;
   logic [15:0] s;
   logic        cout;
   logic        ovf;
   logic        zero;

   int total;
   int bad;

   add16 #(.WIDTH(16), .GROUP(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .X    (X),
      .Y    (Y),
      .cin  (cin),
      .s    (s),
      .cout (cout),
      .ovf  (ovf),
      .zero (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: unsigned and signed sums done with plain integer arithmetic.
   task automatic check_result(input logic [15:0] x, input logic [15:0] y, input logic ci);
      logic [16:0] usum;
      int          ssum;
      logic [15:0] es;
      string       id;
      usum = {1'b0, x} + {1'b0, y} + {16'b0, ci};
      ssum = int'($signed(x)) + int'($signed(y)) + int'(ci);
      es   = usum[15:0];
      id   = $sformatf("%04h+%04h+%0d", x, y, ci);
      check_eq({"s ", id},    {16'b0, s},    {16'b0, es});
      check_eq({"cout ", id}, {31'b0, cout}, {31'b0, usum[16]});
      check_eq({"ovf ", id},  {31'b0, ovf},  {31'b0, (ssum > 32767 || ssum < -32768)});
      check_eq({"zero ", id}, {31'b0, zero}, {31'b0, (es == 16'h0000)});
   endtask

   task automatic apply(input logic [15:0] x, input logic [15:0] y, input logic ci);
      @(negedge clk);
      X   = x;
      Y   = y;
      cin = ci;
      @(posedge clk);
      #1;
      check_result(x, y, ci);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, " s"},    {16'b0, s},    32'h0);
      check_eq({tag, " cout"}, {31'b0, cout}, 32'h0);
      check_eq({tag, " ovf"},  {31'b0, ovf},  32'h0);
      check_eq({tag, " zero"}, {31'b0, zero}, 32'h1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      // Inputs that would set cout/zero if reset were ignored.
      X     = 16'hFFFF;
      Y     = 16'h0001;
      cin   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");

      @(negedge clk);
      rst_n = 1'b1;

      apply(16'h0001, 16'h0000, 1'b0);
      apply(16'h0000, 16'h0000, 1'b0);
      apply(16'h0000, 16'h0001, 1'b0);
      apply(16'h0001, 16'h0001, 1'b0);
      apply(16'hFFFF, 16'h0001, 1'b0);
      apply(16'h7FFF, 16'h0001, 1'b0);
      apply(16'h8000, 16'h8000, 1'b0);
      apply(16'h000F, 16'h0000, 1'b1);
      apply(16'h00FF, 16'h0000, 1'b1);
      apply(16'h0FFF, 16'h0000, 1'b1);
      apply(16'hFFFF, 16'hFFFF, 1'b1);
      apply(16'hFFFF, 16'h0000, 1'b1);
      apply(16'h8000, 16'hFFFF, 1'b0);
      apply(16'h7FFF, 16'h7FFF, 1'b1);

      // Reset mid-stream overrides the add in progress.
      @(negedge clk);
      X     = 16'h1234;
      Y     = 16'h1111;
      cin   = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_state("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("after reset s", {16'b0, s}, 32'h2345);
      check_eq("after reset zero", {31'b0, zero}, 32'h0);

      // Back-to-back random operations, one per clock.
      for (int i = 0; i < 300; i++) begin
         apply(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
